mdu_seq: RTL

- Iterative multiply/divide sequencer beside the single-cycle ALU in the execute stage.
- Accepts one operation at a time from decode/issue through a valid/ready handshake and runs a radix-2 shift-add or shift-subtract loop for WIDTH cycles.
- Holds the 2*WIDTH-bit result until execute consumes it.
- Issue stalls the pipeline on ready_o/valid_o; kill_i discards in-flight work on a branch flush.

---
 rtl/mdu_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mdu_seq.sv
// Iterative radix-2 multiply/divide sequencer for the execute stage.
// One request at a time: WIDTH shift-add/shift-subtract cycles, one sign-fix
// cycle, then the 2*WIDTH-bit result is held until the consumer takes it.
module mdu_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             n_reset_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] rd_i,
   input  logic [WIDTH-1:0] rs_i,
   input  logic             kill_i,
   output logic             valid_o,
   input  logic             yumi_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             busy_o
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e               state_q;
   logic [CntW-1:0]      cnt_q;
   logic                 is_div_q;
   logic [2*WIDTH-1:0]   acc_q;      // mul: product:multiplier, div: remainder:quotient
   logic [WIDTH-1:0]     opnd_q;     // multiplicand or divisor magnitude
   logic [WIDTH-1:0]     rd_raw_q;   // dividend as presented, for divide-by-zero
   logic                 neg_lo_q;
   logic                 neg_hi_q;
   logic                 div_zero_q;
   logic [WIDTH-1:0]     hi_q;
   logic [WIDTH-1:0]     lo_q;

   // Operand magnitudes and result signs captured at accept
   logic                 sign_a, sign_b;
   logic [WIDTH-1:0]     mag_a, mag_b;

   // One radix-2 step and the sign/special-case fix-up
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH-1:0]     div_diff;
   logic [WIDTH-1:0]     div_rem;
   logic                 div_ge;
   logic [2*WIDTH-1:0]   step_acc;
   logic [2*WIDTH-1:0]   prod_res;
   logic [WIDTH-1:0]     fix_hi, fix_lo;

   // Decode operand signs and magnitudes of the incoming request
   always_comb begin
      sign_a = op_i[0] & rd_i[WIDTH-1];
      sign_b = op_i[0] & rs_i[WIDTH-1];
      mag_a  = sign_a ? -rd_i : rd_i;
      mag_b  = sign_b ? -rs_i : rs_i;
   end

   // Next accumulator value for one multiply or restoring-divide step
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, opnd_q};
      // When the trial subtract succeeds the true difference fits in WIDTH bits
      div_diff  = div_shift[WIDTH-1:0] - opnd_q;
      div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
      if (is_div_q) begin
         step_acc = {div_rem, acc_q[WIDTH-2:0], div_ge};
      end else begin
         step_acc = {mul_sum, acc_q[WIDTH-1:1]};
      end
   end

   // Apply recorded signs and the divide-by-zero override to the raw result
   always_comb begin
      prod_res = neg_lo_q ? -acc_q : acc_q;
      if (is_div_q) begin
         if (div_zero_q) begin
            fix_lo = '1;
            fix_hi = rd_raw_q;
         end else begin
            fix_lo = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            fix_hi = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
         end
      end else begin
         fix_lo = prod_res[WIDTH-1:0];
         fix_hi = prod_res[2*WIDTH-1:WIDTH];
      end
   end

   // Sequencer FSM and datapath registers; kill has priority over everything
   always_ff @(posedge clk_i or negedge n_reset_i) begin
      if (!n_reset_i) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         is_div_q   <= 1'b0;
         acc_q      <= '0;
         opnd_q     <= '0;
         rd_raw_q   <= '0;
         neg_lo_q   <= 1'b0;
         neg_hi_q   <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else if (kill_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (valid_i) begin
                  state_q    <= StCalc;
                  cnt_q      <= CntW'(WIDTH);
                  is_div_q   <= op_i[1];
                  acc_q      <= {{WIDTH{1'b0}}, (op_i[1] ? mag_a : mag_b)};
                  opnd_q     <= op_i[1] ? mag_b : mag_a;
                  rd_raw_q   <= rd_i;
                  neg_lo_q   <= sign_a ^ sign_b;
                  neg_hi_q   <= op_i[1] ? sign_a : (sign_a ^ sign_b);
                  div_zero_q <= op_i[1] & (rs_i == '0);
               end
            end
            StCalc: begin
               acc_q <= step_acc;
               cnt_q <= cnt_q - CntW'(1);
               if (cnt_q == CntW'(1)) begin
                  state_q <= StFix;
               end
            end
            StFix: begin
               hi_q    <= fix_hi;
               lo_q    <= fix_lo;
               state_q <= StDone;
            end
            StDone: begin
               if (yumi_i) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign ready_o = (state_q == StIdle);
   assign valid_o = (state_q == StDone);
   assign busy_o  = (state_q == StCalc) || (state_q == StFix);
   assign hi_o    = hi_q;
   assign lo_o    = lo_q;

endmodule
